// File: rtl/reflet_synth_sequencer.sv
// reflet_synth_sequencer: bus-mapped note FIFO that plays {shape,tone,duration} notes into the synth generator
// Ports: clk, reset (async active-low); enable/addr/write_en/data_in/data_out form the bus slave
//        (CTRL at base_addr, NOTE at base_addr+1, DUR at base_addr+2); shape/tone drive the generator;
//        busy is high while the sequencer is loading, playing or gapping a note.
module reflet_synth_sequencer #(
    parameter int base_addr_size = 16,
    parameter logic [base_addr_size-1:0] base_addr = 16'hFF22,
    parameter int clk_freq = 1000000,
    parameter int fifo_depth = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic                      write_en,
    input  logic [7:0]                data_in,
    output logic [7:0]                data_out,
    output logic [1:0]                shape,
    output logic [5:0]                tone,
    output logic                      busy
);
    localparam int tick_len = clk_freq / 100;
    localparam int pw = $clog2(tick_len);
    localparam int aw = $clog2(fifo_depth);
    localparam logic [pw-1:0] tick_max = pw'(tick_len - 1);
    localparam logic [aw:0] depth = (aw+1)'(fifo_depth);
    typedef enum logic [1:0] {s_idle, s_load, s_play, s_gap} state_t;
    state_t state, next_load;
    logic run, gap_en, sel_ctrl, sel_note, sel_dur, ctrl_wr, flush, abort;
    logic push, pop, empty, full, tick;
    logic [7:0] note, cur;
    logic [15:0] mem [fifo_depth];
    logic [15:0] head;
    logic [aw-1:0] rd_ptr, wr_ptr;
    logic [aw:0] count;
    logic [8:0] remaining;
    logic [pw-1:0] presc;
    assign sel_ctrl = enable && addr == base_addr;
    assign sel_note = enable && addr == base_addr + base_addr_size'(1);
    assign sel_dur = enable && addr == base_addr + base_addr_size'(2);
    assign ctrl_wr = sel_ctrl && write_en;
    assign flush = ctrl_wr && data_in[2];
    // Clearing run or flushing kills the current note on the edge of the CTRL write itself.
    assign abort = ctrl_wr && (data_in[2] || !data_in[0]);
    assign empty = count == '0;
    assign full = count == depth;
    assign head = mem[rd_ptr];
    assign pop = state == s_load && !abort;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
    assign push = sel_dur && write_en && (!full || pop);
    assign tick = presc == tick_max;
    assign next_load = run && !empty ? s_load : s_idle;
    assign busy = state != s_idle;
    assign data_out = sel_ctrl ? {4'(count), full, busy, gap_en, run} : sel_note ? note : 8'h00;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {note, data_in};
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            run <= 1'b0;
            gap_en <= 1'b0;
            note <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (ctrl_wr) begin
                run <= data_in[0];
                gap_en <= data_in[1];
            end
            if (sel_note && write_en) note <= data_in;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + aw'(1);
                if (pop) rd_ptr <= rd_ptr + aw'(1);
                count <= count + (aw+1)'(push) - (aw+1)'(pop);
            end
        end
    // Outputs follow the registered state, so shape/tone lag each state change by one cycle.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= s_idle;
            presc <= '0;
            cur <= '0;
            remaining <= '0;
            shape <= '0;
            tone <= '0;
        end else begin
            presc <= state == s_load || tick ? '0 : presc + pw'(1);
            shape <= state == s_play ? cur[7:6] : 2'b00;
            tone <= state == s_play ? cur[5:0] : tone;
            if (abort) state <= s_idle;
            else case (state)
                s_idle: if (run && !empty) state <= s_load;
                s_load: begin
                    cur <= head[15:8];
                    // duration 0 encodes 256 ticks
                    remaining <= {head[7:0] == 8'h00, head[7:0]};
                    state <= s_play;
                end
                s_play: if (tick) begin
                    remaining <= remaining - 9'd1;
                    if (remaining == 9'd1) state <= gap_en ? s_gap : next_load;
                end
                s_gap: if (tick) state <= next_load;
                default: state <= s_idle;
            endcase
        end
endmodule

// File: tb/tb_reflet_synth_sequencer.sv
// tb_reflet_synth_sequencer: scoreboard bench comparing played notes against a queue-based note model
module tb_reflet_synth_sequencer;
    localparam int p = 10;
    localparam logic [15:0] a_ctrl = 16'hFF22;
    localparam logic [15:0] a_note = 16'hFF23;
    localparam logic [15:0] a_dur = 16'hFF24;
    logic clk = 1'b0;
    logic reset, enable, write_en, busy;
    logic [15:0] addr;
    logic [7:0] data_in, data_out;
    logic [1:0] shape;
    logic [5:0] tone;
    int n_chk = 0;
    int n_fail = 0;
    typedef struct {logic [1:0] s; logic [5:0] t; int len; int gap;} note_t;
    note_t mfifo[$];
    note_t exp_q[$];
    note_t e_m;
    bit mon_on = 1'b0;
    logic [1:0] ps;
    logic [5:0] pt;
    int run_len, zero_len;

    reflet_synth_sequencer #(.clk_freq(1000)) dut (
        .clk(clk), .reset(reset), .enable(enable), .addr(addr), .write_en(write_en),
        .data_in(data_in), .data_out(data_out), .shape(shape), .tone(tone), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    // Monitor: measures each contiguous non-silent {shape,tone} run and the silence before it.
    always @(negedge clk) begin
        if (!mon_on) begin
            ps = 2'd0;
            pt = 6'd0;
            run_len = 0;
            zero_len = 0;
        end else begin
            if (shape != 2'd0 && shape == ps && tone == pt) run_len++;
            else if (shape == 2'd0 && ps == 2'd0) zero_len++;
            else begin
                if (ps != 2'd0) begin
                    chk("note_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e_m = exp_q.pop_front();
                        chk("note_shape", ps, e_m.s);
                        chk("note_tone", pt, e_m.t);
                        chk("note_len", run_len, e_m.len);
                    end
                    zero_len = 0;
                end
                if (shape != 2'd0) begin
                    if (exp_q.size() > 0 && exp_q[0].gap >= 0) chk("note_gap", zero_len, exp_q[0].gap);
                    run_len = 1;
                end else zero_len = 1;
            end
            ps = shape;
            pt = tone;
        end
    end

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        enable = 1'b1;
        addr = a;
        write_en = 1'b1;
        data_in = d;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        write_en = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        enable = 1'b1;
        addr = a;
        write_en = 1'b0;
        #1;
        d = data_out;
        enable = 1'b0;
    endtask

    // Model: a note occupies dur ticks (0 means 256); pushes beyond 8 stored notes are dropped.
    task automatic push_note(input logic [1:0] s, input logic [5:0] t, input logic [7:0] d);
        note_t n;
        wr(a_note, {s, t});
        wr(a_dur, d);
        n.s = s;
        n.t = t;
        n.len = (d == 8'd0 ? 256 : int'(d)) * p;
        n.gap = -1;
        if (mfifo.size() < 8) mfifo.push_back(n);
    endtask

    task automatic wait_idle(input int lim);
        int i = 0;
        repeat (2) @(negedge clk);
        while (busy && i < lim) begin
            @(negedge clk);
            i++;
        end
        chk("reach_idle", busy, 0);
    endtask

    task automatic wait_shape(input int lim);
        int i = 0;
        while (shape == 2'd0 && i < lim) begin
            @(negedge clk);
            i++;
        end
        chk("note_started", shape != 2'd0, 1);
    endtask

    // Silence between notes: one LOAD cycle, plus one tick of GAP when gap_en is set.
    task automatic play(input bit g);
        foreach (mfifo[i]) begin
            mfifo[i].gap = i == 0 ? -1 : (g ? p + 1 : 1);
            exp_q.push_back(mfifo[i]);
        end
        mfifo.delete();
        wr(a_ctrl, {6'b0, g, 1'b1});
        wait_idle(20000);
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        wr(a_ctrl, 8'h00);
    endtask

    initial begin
        logic [7:0] v;
        int n;
        reset = 1'b0;
        enable = 1'b0;
        write_en = 1'b0;
        addr = '0;
        data_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_shape", shape, 0);
        chk("rst_busy", busy, 0);
        rd(a_ctrl, v);
        chk("rst_ctrl", v, 0);
        rd(a_note, v);
        chk("rst_note", v, 0);
        reset = 1'b1;
        @(negedge clk);
        mon_on = 1'b1;
        push_note(2'd1, 6'd32, 8'd3);
        rd(a_note, v);
        chk("note_readback", v, 8'h60);
        rd(a_dur, v);
        chk("dur_reads_zero", v, 0);
        play(1'b0);
        push_note(2'($urandom_range(1, 3)), 6'($urandom_range(0, 63)), 8'd1);
        push_note(2'($urandom_range(1, 3)), 6'($urandom_range(0, 63)), 8'd2);
        push_note(2'($urandom_range(1, 3)), 6'($urandom_range(0, 63)), 8'd1);
        play(1'b1);
        for (int i = 0; i < 9; i++)
            push_note(2'($urandom_range(1, 3)), 6'($urandom_range(0, 63)), 8'($urandom_range(1, 3)));
        rd(a_ctrl, v);
        chk("full_ctrl", v, {4'(mfifo.size()), mfifo.size() == 8, 3'b000});
        play(1'b0);
        push_note(2'd3, 6'd5, 8'd0);
        play(1'b0);
        repeat (6) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++)
                push_note(2'($urandom_range(1, 3)), 6'($urandom_range(0, 63)), 8'($urandom_range(1, 4)));
            play(1'($urandom_range(0, 1)));
        end
        mon_on = 1'b0;
        push_note(2'd2, 6'd9, 8'd0);
        push_note(2'd1, 6'd1, 8'd2);
        mfifo.delete();
        wr(a_ctrl, 8'h01);
        wait_shape(100);
        repeat (99) @(negedge clk);
        chk("long_note_on", shape, 2);
        wr(a_ctrl, 8'h00);
        chk("abort_busy", busy, 0);
        rd(a_ctrl, v);
        chk("abort_count_kept", v, 8'h10);
        @(negedge clk);
        chk("abort_shape", shape, 0);
        wr(a_ctrl, 8'h04);
        rd(a_ctrl, v);
        chk("flush_empty", v, 8'h00);
        for (int i = 0; i < 8; i++)
            push_note(2'($urandom_range(1, 3)), 6'($urandom_range(0, 63)), 8'd2);
        rd(a_ctrl, v);
        chk("full_again", v, 8'h88);
        wr(a_ctrl, 8'h01);
        @(negedge clk);
        chk("load_busy", busy, 1);
        wr(a_dur, 8'd4);
        rd(a_ctrl, v);
        chk("push_during_pop", v, 8'h8D);
        repeat (5) @(negedge clk);
        chk("head_shape", shape, mfifo[0].s);
        chk("head_tone", tone, mfifo[0].t);
        wr(a_ctrl, 8'h05);
        chk("flush_busy", busy, 0);
        rd(a_ctrl, v);
        chk("flush_ctrl", v, 8'h01);
        @(negedge clk);
        chk("flush_shape", shape, 0);
        wr(a_ctrl, 8'h00);
        mfifo.delete();
        push_note(2'd1, 6'd7, 8'd3);
        push_note(2'd3, 6'd8, 8'd3);
        mfifo.delete();
        wr(a_ctrl, 8'h01);
        wait_shape(100);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midplay_rst_shape", shape, 0);
        chk("midplay_rst_busy", busy, 0);
        rd(a_ctrl, v);
        chk("midplay_rst_ctrl", v, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
